axis_tdest_classifier: RTL and testbench
========================================

Name: axis_tdest_classifier

Overview:
- Parametrised AXI4-Stream packet classifier, successor to the first-beat tdest mapper in the CSO receive path. It sits between the MAC RX stream and the multi-channel S2MM DMA.
- On the first beat of each packet it extracts a configurable header field. That field becomes the packet's tdest, and it is held constant for every beat of the packet.
- Out-of-range field values are steered to a programmable default channel.
- The output is fully registered through a 2-entry skid buffer, so tdest/tdata/tvalid carry no combinational path from the slave side.
- Per-packet statistics counters are provided.

Parameters:
- TDATA_WIDTH, 64, stream data width in bits (multiple of 8).
- TKEEP_WIDTH, TDATA_WIDTH/8, byte-enable width.
- TUSER_WIDTH, 1, sideband width, passed through unchanged.
- TDEST_WIDTH, 4, output tdest width.
- FIELD_LSB, TDATA_WIDTH-TDEST_WIDTH-1, bit position of the class field in the first beat. Legal range is 0..TDATA_WIDTH-TDEST_WIDTH.
- NUM_CHANNELS, 16, number of valid destinations, 1..2^TDEST_WIDTH. Field values >= NUM_CHANNELS are unmapped.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, asynchronous active-low reset.
- s_axis_tvalid, input, 1, slave valid.
- s_axis_tready, output, 1, slave ready.
- s_axis_tdata, input, TDATA_WIDTH, slave data.
- s_axis_tkeep, input, TKEEP_WIDTH, slave byte enables.
- s_axis_tlast, input, 1, end of packet.
- s_axis_tuser, input, TUSER_WIDTH, slave sideband.
- m_axis_s2mm_tvalid, output, 1, master valid.
- m_axis_s2mm_tready, input, 1, master ready.
- m_axis_s2mm_tdata, output, TDATA_WIDTH, master data.
- m_axis_s2mm_tkeep, output, TKEEP_WIDTH, master byte enables.
- m_axis_s2mm_tlast, output, 1, master end of packet.
- m_axis_s2mm_tuser, output, TUSER_WIDTH, master sideband.
- m_axis_s2mm_tdest, output, TDEST_WIDTH, destination channel.
- cfg_default_dest, input, TDEST_WIDTH, channel used for unmapped packets. It is quasi-static and sampled on each first beat.
- stat_clear, input, 1, synchronous clear of both counters.
- stat_pkt_cnt, output, CNT_WIDTH, packets accepted (counted on tlast).
- stat_unmapped_cnt, output, CNT_WIDTH, packets sent to cfg_default_dest.

Behaviour:
- Reset values, asserted asynchronously: s_axis_tready=0, m_axis_s2mm_tvalid=0, all m_axis_s2mm_* data fields 0, sop=1, dest_hold=0, skid empty, both counters 0.
- tready release: s_axis_tready rises on the first clk edge after reset deasserts.
- Accept: a slave beat is accepted when s_axis_tvalid && s_axis_tready.
- Registered ready: s_axis_tready = !skid_valid, taken from a register.
- Latency and throughput: an accepted beat appears on the master side 1 cycle later. Sustained throughput is 1 beat/clk when m_axis_s2mm_tready=1.
- Skid buffer: if the output register is occupied and not draining, the incoming beat goes to the skid register and s_axis_tready drops next cycle. When the output drains, the skid moves to the output and tready reasserts.
- Ordering: beats are never dropped, duplicated or reordered.
- Master stability: while m_axis_s2mm_tvalid=1 and m_axis_s2mm_tready=0, all m_axis_s2mm_* outputs hold stable.
- SOP tracking: sop=1 marks the next accepted beat as a first beat. Accepting a beat with tlast sets sop=1; any other accepted beat clears it.
- Classification, on an accepted first beat:
  - field = s_axis_tdata[FIELD_LSB +: TDEST_WIDTH].
  - If field < NUM_CHANNELS, dest = field. Otherwise dest = cfg_default_dest and the beat is flagged unmapped.
  - dest is written to dest_hold and travels with the beat.
- Non-first beats use dest_hold, so tdest is constant across the whole packet, including when backpressure occurs mid-packet.
- Single-beat packet (first beat with tlast): classified, sop stays 1, and both counters update the same cycle.
- Counters:
  - stat_pkt_cnt increments on an accepted tlast beat.
  - stat_unmapped_cnt increments on an accepted first beat that is unmapped.
  - Both saturate at all-ones.
  - stat_clear takes priority over a coincident increment; the result is 0.
- Reset mid-packet: all state is dropped and sop=1. The next accepted beat is treated as a first beat.
- No tuser-based drop. tkeep/tuser pass through unmodified.

Decomposition:
- Shared package axis_cls_pkg holds the localparam defaults (TDEST_WIDTH, CNT_WIDTH) and the saturating-increment function.
- One sub-module, axis_skid_reg: a 2-entry registered skid buffer carrying {tdata, tkeep, tlast, tuser, tdest}, parametrised by payload width.
- Classifier, SOP tracker and counters live in the top module.

Test Plan:
- 3-beat packet, beat0 field=5, continuous tready -> tdest=5 on all 3 beats, first output 1 cycle after accept, stat_pkt_cnt=1, stat_unmapped_cnt=0.
- NUM_CHANNELS=8, field=12, cfg_default_dest=3 -> tdest=3 on every beat, stat_unmapped_cnt=1.
- Back-to-back single-beat packets with fields 1,2,7, no gaps -> tdest sequence 1,2,7 at 1 beat/clk; stat_pkt_cnt=3.
- 8-beat packet with m_axis_s2mm_tready toggled randomly (including 0 for 5 cycles) -> s_axis_tready falls within 1 cycle of stall; output sequence identical to input; outputs stable while stalled; no loss.
- Reset asserted on beat 3 of 6, then a new packet with field=9 -> tvalid=0 immediately on reset; after release tready=1 next edge; new packet gets tdest=9 and is treated as SOP.
- Force stat_pkt_cnt to all-ones, send 1 packet -> stays all-ones; assert stat_clear coincident with a tlast -> counter=0.

Source files
------------

// File: rtl/axis_cls_pkg.sv
// Shared defaults and helpers for the AXI4-Stream tdest classifier.
// The saturating increment works on a 64-bit container so one function serves any counter width.
package axis_cls_pkg;

  localparam int DEF_TDEST_WIDTH = 4;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int SAT_MAX_WIDTH   = 64;

  function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
    input logic [SAT_MAX_WIDTH-1:0] value,
    input int                       width
  );
    logic [SAT_MAX_WIDTH-1:0] max_val;
    if (width >= SAT_MAX_WIDTH) begin
      max_val = '1;
    end else begin
      max_val = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
    end
    return (value >= max_val) ? max_val : value + SAT_MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer: output register plus one spill slot.
// Upstream ready comes straight from a flop, so nothing on the master side is combinational from the slave side.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             out_valid_reg, out_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             ready_reg;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             accept;
  logic             drain;

  always_comb begin
    accept          = s_valid && ready_reg;
    drain           = m_ready || !out_valid_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (drain) begin
      if (skid_valid_reg) begin
        // Older beat in the spill slot always goes out first to preserve order.
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = accept;
        if (accept) begin
          skid_data_next = s_data;
        end
      end else begin
        out_valid_next = accept;
        if (accept) begin
          out_data_next = s_data;
        end
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = s_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      ready_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      ready_reg      <= !skid_valid_next;
    end
  end

  assign s_ready = ready_reg;
  assign m_valid = out_valid_reg;
  assign m_data  = out_data_reg;

endmodule

// File: rtl/axis_tdest_classifier.sv
// First-beat header classifier: picks tdest from a header field, holds it for the whole packet,
// steers unmapped values to a default channel and keeps per-packet statistics.
module axis_tdest_classifier
  import axis_cls_pkg::*;
#(
  parameter int TDATA_WIDTH  = 64,
  parameter int TKEEP_WIDTH  = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH  = 1,
  parameter int TDEST_WIDTH  = DEF_TDEST_WIDTH,
  parameter int FIELD_LSB    = TDATA_WIDTH - TDEST_WIDTH - 1,
  parameter int NUM_CHANNELS = 16,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  output logic                   m_axis_s2mm_tvalid,
  input  logic                   m_axis_s2mm_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_s2mm_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_s2mm_tkeep,
  output logic                   m_axis_s2mm_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_s2mm_tuser,
  output logic [TDEST_WIDTH-1:0] m_axis_s2mm_tdest,
  input  logic [TDEST_WIDTH-1:0] cfg_default_dest,
  input  logic                   stat_clear,
  output logic [CNT_WIDTH-1:0]   stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]   stat_unmapped_cnt
);

  localparam int PAYLOAD_WIDTH = TDATA_WIDTH + TKEEP_WIDTH + 1 + TUSER_WIDTH + TDEST_WIDTH;
  // One extra bit so NUM_CHANNELS == 2**TDEST_WIDTH compares correctly.
  localparam logic [TDEST_WIDTH:0] NUM_CH = (TDEST_WIDTH + 1)'(NUM_CHANNELS);

  logic                     sop_reg;
  logic [TDEST_WIDTH-1:0]   dest_hold_reg;
  logic [CNT_WIDTH-1:0]     pkt_cnt_reg, pkt_cnt_next;
  logic [CNT_WIDTH-1:0]     unmapped_cnt_reg, unmapped_cnt_next;
  logic                     accept;
  logic [TDEST_WIDTH-1:0]   field;
  logic                     mapped;
  logic [TDEST_WIDTH-1:0]   first_dest;
  logic [TDEST_WIDTH-1:0]   beat_dest;
  logic                     unmapped_hit;
  logic                     last_hit;
  logic [PAYLOAD_WIDTH-1:0] s_payload;
  logic [PAYLOAD_WIDTH-1:0] m_payload;

  always_comb begin
    accept       = s_axis_tvalid && s_axis_tready;
    field        = s_axis_tdata[FIELD_LSB +: TDEST_WIDTH];
    mapped       = {1'b0, field} < NUM_CH;
    first_dest   = mapped ? field : cfg_default_dest;
    beat_dest    = sop_reg ? first_dest : dest_hold_reg;
    unmapped_hit = accept && sop_reg && !mapped;
    last_hit     = accept && s_axis_tlast;

    pkt_cnt_next      = pkt_cnt_reg;
    unmapped_cnt_next = unmapped_cnt_reg;
    // Clear wins over a same-cycle increment.
    if (stat_clear) begin
      pkt_cnt_next      = '0;
      unmapped_cnt_next = '0;
    end else begin
      if (last_hit) begin
        pkt_cnt_next = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(pkt_cnt_reg), CNT_WIDTH));
      end
      if (unmapped_hit) begin
        unmapped_cnt_next = CNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(unmapped_cnt_reg), CNT_WIDTH));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sop_reg          <= 1'b1;
      dest_hold_reg    <= '0;
      pkt_cnt_reg      <= '0;
      unmapped_cnt_reg <= '0;
    end else begin
      if (accept) begin
        sop_reg <= s_axis_tlast;
      end
      if (accept && sop_reg) begin
        dest_hold_reg <= first_dest;
      end
      pkt_cnt_reg      <= pkt_cnt_next;
      unmapped_cnt_reg <= unmapped_cnt_next;
    end
  end

  assign s_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, beat_dest};

  axis_skid_reg #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_axis_tvalid),
    .s_ready(s_axis_tready),
    .s_data (s_payload),
    .m_valid(m_axis_s2mm_tvalid),
    .m_ready(m_axis_s2mm_tready),
    .m_data (m_payload)
  );

  assign {m_axis_s2mm_tdata, m_axis_s2mm_tkeep, m_axis_s2mm_tlast,
          m_axis_s2mm_tuser, m_axis_s2mm_tdest} = m_payload;

  assign stat_pkt_cnt      = pkt_cnt_reg;
  assign stat_unmapped_cnt = unmapped_cnt_reg;

endmodule

// File: tb/tb_axis_tdest_classifier.sv
// Bench for axis_tdest_classifier: directed scenarios plus randomized packets, checked against
// a packet-level expected-beat queue and counter model.
module tb_axis_tdest_classifier;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int UW    = 1;
  localparam int DESTW = 4;
  localparam int LSB   = DW - DESTW - 1;
  localparam int NCH   = 12;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [DW-1:0]    s_tdata = '0;
  logic [KW-1:0]    s_tkeep = '0;
  logic             s_tlast = 1'b0;
  logic [UW-1:0]    s_tuser = '0;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic [UW-1:0]    m_tuser;
  logic [DESTW-1:0] m_tdest;
  logic [DESTW-1:0] cfg_dest = '0;
  logic             stat_clear = 1'b0;
  logic [CW-1:0]    pkt_cnt;
  logic [CW-1:0]    unm_cnt;

  axis_tdest_classifier #(
    .TDATA_WIDTH (DW),
    .TKEEP_WIDTH (KW),
    .TUSER_WIDTH (UW),
    .TDEST_WIDTH (DESTW),
    .FIELD_LSB   (LSB),
    .NUM_CHANNELS(NCH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tdata      (s_tdata),
    .s_axis_tkeep      (s_tkeep),
    .s_axis_tlast      (s_tlast),
    .s_axis_tuser      (s_tuser),
    .m_axis_s2mm_tvalid(m_tvalid),
    .m_axis_s2mm_tready(m_tready),
    .m_axis_s2mm_tdata (m_tdata),
    .m_axis_s2mm_tkeep (m_tkeep),
    .m_axis_s2mm_tlast (m_tlast),
    .m_axis_s2mm_tuser (m_tuser),
    .m_axis_s2mm_tdest (m_tdest),
    .cfg_default_dest  (cfg_dest),
    .stat_clear        (stat_clear),
    .stat_pkt_cnt      (pkt_cnt),
    .stat_unmapped_cnt (unm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [KW-1:0]    keep;
    logic             last;
    logic [UW-1:0]    user;
    logic [DESTW-1:0] dest;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int    model_pkt = 0;
  int    model_unm = 0;

  always @(posedge clk) cyc++;

  // Sink ready changes well after the edge and stays put until the next one.
  always begin
    @(posedge clk);
    #2;
    if (rdy_mode == 0) m_tready = 1'b1;
    else if (rdy_mode == 2) m_tready = 1'b0;
    else m_tready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: ordering, payload, tdest, and stability under stall.
  logic  prev_stall = 1'b0;
  beat_t prev_bus;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser, dest: m_tdest};
    if (rst_n) begin
      if (prev_stall) check("stall_stable", {m_tvalid, cur}, {1'b1, prev_bus});
      if (m_tvalid && m_tready) begin
        check("unexpected_beat", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tdata", m_tdata, e.data);
          check("tkeep", m_tkeep, e.keep);
          check("tlast", m_tlast, e.last);
          check("tuser", m_tuser, e.user);
          check("tdest", m_tdest, e.dest);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_bus   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_beat(input beat_t b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    s_tdata  = b.data;
    s_tkeep  = b.keep;
    s_tlast  = b.last;
    s_tuser  = b.user;
    s_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = (s_tready === 1'b1);
      @(posedge clk);
      n++;
    end
    #1;
    s_tvalid = 1'b0;
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  function automatic beat_t make_beat(input int idx, input int len, input int field,
                                      input logic [DESTW-1:0] dest);
    beat_t b;
    b.data = $urandom;
    if (idx == 0) b.data[LSB +: DESTW] = DESTW'(field);
    b.keep = KW'($urandom);
    b.last = (idx == len - 1);
    b.user = UW'($urandom);
    b.dest = dest;
    return b;
  endfunction

  task automatic send_pkt(input int len, input int field, input bit chk_lat);
    logic [DESTW-1:0] dest;
    beat_t            b;
    dest = (field < NCH) ? DESTW'(field) : cfg_dest;
    model_pkt = (model_pkt < CMAX) ? model_pkt + 1 : CMAX;
    if (field >= NCH) model_unm = (model_unm < CMAX) ? model_unm + 1 : CMAX;
    for (int i = 0; i < len; i++) begin
      b = make_beat(i, len, field, dest);
      exp_q.push_back(b);
      send_beat(b);
      if (chk_lat && i == 0) begin
        check("latency_valid", 64'(m_tvalid), 64'd1);
        check("latency_dest", 64'(m_tdest), 64'(dest));
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pkt"}, 64'(pkt_cnt), 64'(model_pkt));
    check({tag, "_unm"}, 64'(unm_cnt), 64'(model_unm));
  endtask

  initial begin
    beat_t b;
    beat_t stall_pkt[8];
    int    c0;
    int    len;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tdest", 64'(m_tdest), 64'd0);
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_tready_before_edge", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_tready_after_edge", 64'(s_tready), 64'd1);

    // 3-beat mapped packet with latency check
    send_pkt(3, 5, 1'b1);
    wait_drain();
    check_counters("t1");

    // Unmapped field goes to default channel
    cfg_dest = 4'd3;
    send_pkt(3, 12, 1'b1);
    wait_drain();
    check_counters("t2");

    // Back-to-back single-beat packets at full rate
    c0 = cyc;
    send_pkt(1, 1, 1'b0);
    send_pkt(1, 2, 1'b0);
    send_pkt(1, 7, 1'b0);
    check("b2b_cycles", 64'(cyc - c0), 64'd3);
    wait_drain();
    check_counters("t3");

    // 8-beat packet with a hard 5-cycle stall then random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      stall_pkt[i] = make_beat(i, 8, 6, 4'd6);
      exp_q.push_back(stall_pkt[i]);
    end
    model_pkt = (model_pkt < CMAX) ? model_pkt + 1 : CMAX;
    send_beat(stall_pkt[0]);
    send_beat(stall_pkt[1]);
    check("stall_tready_drop", 64'(s_tready), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("stall_tready_held", 64'(s_tready), 64'd0);
    check("stall_tvalid_held", 64'(m_tvalid), 64'd1);
    rdy_mode = 1;
    for (int i = 2; i < 8; i++) send_beat(stall_pkt[i]);

    // Randomized traffic under random backpressure
    for (int p = 0; p < 25; p++) begin
      cfg_dest = DESTW'($urandom);
      len = $urandom_range(1, 5);
      send_pkt(len, $urandom_range(0, 15), 1'b0);
    end
    rdy_mode = 0;
    wait_drain();
    check_counters("rand");

    // Saturation: one more packet keeps the count pinned
    send_pkt(1, 13, 1'b0);
    wait_drain();
    check("sat_pkt", 64'(pkt_cnt), 64'(CMAX));
    check_counters("sat");

    // Clear coincident with an unmapped single-beat packet
    stat_clear = 1'b1;
    b = make_beat(0, 1, 14, cfg_dest);
    exp_q.push_back(b);
    send_beat(b);
    stat_clear = 1'b0;
    model_pkt = 0;
    model_unm = 0;
    check_counters("clr");
    send_pkt(1, 2, 1'b0);
    wait_drain();
    check_counters("post_clr");

    // Reset on beat 3 of a 6-beat packet
    for (int i = 0; i < 3; i++) begin
      b = make_beat(i, 6, 4, 4'd4);
      exp_q.push_back(b);
      send_beat(b);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_pkt = 0;
    model_unm = 0;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_tready", 64'(s_tready), 64'd0);
    check("midrst_tdata", 64'(m_tdata), 64'd0);
    check_counters("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release", 64'(s_tready), 64'd1);
    cfg_dest = 4'd0;
    send_pkt(2, 9, 1'b1);
    wait_drain();
    check_counters("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
